// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - op-code encodings for md_op (4 bits)
//   - FSM state and op-class enums
//   - hilo_t payload for the 64-bit {hi,lo} result
//   - md_classify(): maps an op code to mult/div/mt/none
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU as
// mult-class ops. When it is undefined, op codes 7-10 classify as none.
package md_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned XLEN = 32;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd7;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd8;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd9;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MULT = 2'd1,
    CLS_DIV  = 2'd2,
    CLS_MT   = 2'd3
  } md_class_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Latency / side-effect class of an op code; unknown codes are none.
  function automatic md_class_e md_classify(input logic [OP_W-1:0] op);
    md_class_e cls;
    cls = CLS_NONE;
    case (op)
      OP_MULT, OP_MULTU: cls = CLS_MULT;
      OP_DIV, OP_DIVU:   cls = CLS_DIV;
      OP_MTHI, OP_MTLO:  cls = CLS_MT;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MULT;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational result generator for the multiply/divide unit.
// Ports:
//   md_op    in  4   operation code
//   a, b     in  32  operands (rs, rt)
//   hi, lo   in  32  current HI/LO (divide-by-zero hold, accumulate base)
//   result_c out 64  {hi,lo} value to latch as pending
// Optional feature macro: MDU_MADD_EN adds the MADD/MSUB accumulate ops.
module md_calc
  import md_pkg::*;
(
  input  logic [OP_W-1:0]   md_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [XLEN-1:0]   hi,
  input  logic [XLEN-1:0]   lo,
  output logic [2*XLEN-1:0] result_c
);

  logic [2*XLEN-1:0] a_sx;
  logic [2*XLEN-1:0] b_sx;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   mag_q;
  logic [XLEN-1:0]   mag_r;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   quo_u;
  logic [XLEN-1:0]   rem_u;
  logic              div_zero;

  // Low 64 bits of a product do not depend on signedness once operands
  // are extended to 64 bits, so one plain multiplier per flavour suffices.
  assign a_sx   = {{XLEN{a[XLEN-1]}}, a};
  assign b_sx   = {{XLEN{b[XLEN-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  // Signed divide via magnitudes; 0x80000000 is its own magnitude, which
  // makes 0x80000000 / -1 come out as quotient 0x80000000, remainder 0.
  assign a_neg    = a[XLEN-1];
  assign b_neg    = b[XLEN-1];
  assign a_mag    = a_neg ? XLEN'(-a) : a;
  assign b_mag    = b_neg ? XLEN'(-b) : b;
  assign div_zero = (b == '0);
  assign mag_q    = div_zero ? '0 : a_mag / b_mag;
  assign mag_r    = div_zero ? '0 : a_mag % b_mag;
  assign quo_s    = (a_neg ^ b_neg) ? XLEN'(-mag_q) : mag_q;
  assign rem_s    = a_neg ? XLEN'(-mag_r) : mag_r;
  assign quo_u    = div_zero ? '0 : a / b;
  assign rem_u    = div_zero ? '0 : a % b;

  // Result select; divide by zero and unknown ops keep {hi,lo}.
  always_comb begin
    result_c = {hi, lo};
    case (md_op)
      OP_MULT:  result_c = prod_s;
      OP_MULTU: result_c = prod_u;
      OP_DIV:   if (!div_zero) result_c = {rem_s, quo_s};
      OP_DIVU:  if (!div_zero) result_c = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result_c = {hi, lo} + prod_s;
      OP_MADDU: result_c = {hi, lo} + prod_u;
      OP_MSUB:  result_c = {hi, lo} - prod_s;
      OP_MSUBU: result_c = {hi, lo} - prod_u;
`endif
      default:  result_c = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding architectural HI/LO.
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   synchronous active-high reset
//   start  in  1   md instruction valid in E (ignored while busy)
//   md_op  in  4   operation code (md_pkg encodings)
//   a, b   in  32  operands, captured only at the start edge
//   busy   out 1   computation in flight (registered)
//   hi, lo out 32  architectural HI/LO (registered)
// Optional feature macro: MDU_MADD_EN (see md_pkg / md_calc).
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_e         state_q;
  md_state_e         state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  hilo_t             pend_q;
  hilo_t             pend_d;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;
  logic              busy_d;
  logic [2*XLEN-1:0] calc_res;
  md_class_e         op_cls;

  md_calc u_calc (
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .result_c (calc_res)
  );

  assign op_cls = md_classify(md_op);

  // State, counter, pending and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
    end
  end

  // Next-state: launch in IDLE, count down in BUSY, commit at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi;
    lo_d    = lo;
    busy_d  = busy;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_cls)
            CLS_MULT: begin
              state_d = ST_BUSY;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              pend_d  = calc_res;
              busy_d  = 1'b1;
            end
            CLS_DIV: begin
              state_d = ST_BUSY;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              pend_d  = calc_res;
              busy_d  = 1'b1;
            end
            CLS_MT: begin
              if (md_op == OP_MTHI) hi_d = a;
              else                  lo_d = a;
            end
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized bench for md_unit with a
// behavioural {hi,lo} model built on 64-bit integer arithmetic.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference result of an op applied to the {hi,lo} value at start.
  function automatic logic [63:0] model(input int op, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [63:0] acc);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'h0, av};
    ub = {32'h0, bv};
    r  = acc;
    case (op)
      1: r = 64'(sa * sb);
      2: r = ua * ub;
      3: if (bv != 0) r = {32'(sa % sb), 32'(sa / sb)};
      4: if (bv != 0) r = {32'(ua % ub), 32'(ua / ub)};
`ifdef MDU_MADD_EN
      7:  r = acc + 64'(sa * sb);
      8:  r = acc + ua * ub;
      9:  r = acc - 64'(sa * sb);
      10: r = acc - ua * ub;
`endif
      default: r = acc;
    endcase
    return r;
  endfunction

  function automatic int latency(input int op);
    case (op)
      1, 2: return MC;
      3, 4: return DC;
`ifdef MDU_MADD_EN
      7, 8, 9, 10: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op and check busy/hi/lo each cycle until it completes.
  // inj>0 pulses an extra MULT 2x2 start that many cycles into busy.
  task automatic run_op(input int op, input logic [31:0] av, input logic [31:0] bv, input int inj);
    logic [63:0] r;
    int n;
    n = latency(op);
    r = model(op, av, bv, {exp_hi, exp_lo});
    start = 1'b1; md_op = 4'(op); a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0; a = $urandom; b = $urandom;
    for (int k = 1; k <= n; k++) begin
      check("busy_on", 32'(busy), 32'd1);
      check("hold_hi", hi, exp_hi);
      check("hold_lo", lo, exp_lo);
      if (k == inj) begin
        start = 1'b1; md_op = 4'd1; a = 32'd2; b = 32'd2;
      end
      @(posedge clk); #1;
      start = 1'b0; md_op = 4'd0;
    end
    if (n > 0) begin
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end else if (op == 5) begin
      exp_hi = av;
    end else if (op == 6) begin
      exp_lo = av;
    end
    check("busy_off", 32'(busy), 32'd0);
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(longint'($urandom_range(0, 9)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ops[12];
    n_pass = 0; n_total = 0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    reset = 1'b1; start = 1'b0; md_op = 4'd0; a = 32'h0; b = 32'h0;
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b0;

    // Directed steps.
    run_op(1, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi_k", hi, 32'hFFFF_FFFF);
    check("mult_lo_k", lo, 32'hFFFF_FFFA);
    run_op(3, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo_k", lo, 32'hFFFF_FFFD);
    check("div_hi_k", hi, 32'hFFFF_FFFF);
    run_op(4, 32'hFFFF_FFF9, 32'd2, 0);
    check("divu_lo_k", lo, 32'h7FFF_FFFC);
    check("divu_hi_k", hi, 32'h0000_0001);
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo_k", lo, 32'h8000_0000);
    check("ovf_hi_k", hi, 32'h0);
    run_op(5, 32'h1234_5678, 32'h0, 0);
    run_op(6, 32'h9ABC_DEF0, 32'h0, 0);
    check("mt_hi_k", hi, 32'h1234_5678);
    check("mt_lo_k", lo, 32'h9ABC_DEF0);
    run_op(5, 32'd5, 32'h0, 0);
    run_op(6, 32'd6, 32'h0, 0);
    run_op(4, 32'd77, 32'd0, 3);
    check("dz_hi_k", hi, 32'd5);
    check("dz_lo_k", lo, 32'd6);

    // Reset in the middle of a multiply: no late write.
    start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    for (int k = 0; k < MC + 2; k++) begin
      @(posedge clk); #1;
      check("abort_nowr_busy", 32'(busy), 32'd0);
      check("abort_nowr_lo", lo, 32'h0);
    end

    // Accumulate ops (NONE-like when the feature is disabled).
    run_op(5, 32'h0, 32'h0, 0);
    run_op(6, 32'hFFFF_FFFF, 32'h0, 0);
    run_op(8, 32'd1, 32'd1, 0);
`ifdef MDU_MADD_EN
    check("maddu_hi_k", hi, 32'd1);
    check("maddu_lo_k", lo, 32'd0);
`else
    check("maddu_hi_k", hi, 32'd0);
    check("maddu_lo_k", lo, 32'hFFFF_FFFF);
`endif

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      int op;
      int n;
      int inj;
      op  = ops[$urandom_range(0, 11)];
      n   = latency(op);
      inj = (n > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n - 1)) : 0;
      run_op(op, pick_operand(), pick_operand(), inj);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
